// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 mux, with a registered
// valid/ready output stage and a per-grant limit on consecutive accepted beats.
module mux4_rr_arbiter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic [1:0]       s,
  output logic [3:0]       gnt
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StGrant = 1'b1;
  localparam logic [4:0] MaxHold = 5'(MAX_HOLD);

  logic [0:0]       state_q, state_d;
  logic [1:0]       s_q, s_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       hold_cnt_q, hold_cnt_d;
  logic [WIDTH-1:0] y_q, y_d;

  logic [WIDTH-1:0] d_arr [4];
  logic [2:0]       pick_idle, pick_rot;
  logic [4:0]       hold_next;

  assign d_arr[0] = d0;
  assign d_arr[1] = d1;
  assign d_arr[2] = d2;
  assign d_arr[3] = d3;

  // Returns {found, index}; scanning far-to-near lets the entry closest to base win.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = base + k[1:0];
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    y_d        = y_q;
    hold_next  = {1'b0, hold_cnt_q} + 5'd1;
    pick_idle  = rr_pick(req, ptr_q);
    pick_rot   = rr_pick(req, s_q + 2'd1);

    if (state_q == StIdle) begin
      if (pick_idle[2]) begin
        state_d    = StGrant;
        s_d        = pick_idle[1:0];
        y_d        = d_arr[pick_idle[1:0]];
        hold_cnt_d = 4'd0;
      end
    end else if (out_ready) begin
      if (req[s_q] && (hold_next < MaxHold)) begin
        y_d        = d_arr[s_q];
        hold_cnt_d = hold_next[3:0];
      end else begin
        ptr_d = s_q + 2'd1;
        if (pick_rot[2]) begin
          s_d        = pick_rot[1:0];
          y_d        = d_arr[pick_rot[1:0]];
          hold_cnt_d = 4'd0;
        end else begin
          // Nobody left: drop to idle but keep s and y at their last values.
          state_d    = StIdle;
          hold_cnt_d = 4'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      s_q        <= 2'd0;
      ptr_q      <= 2'd0;
      hold_cnt_q <= 4'd0;
      y_q        <= '0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      y_q        <= y_d;
    end
  end

  assign out_valid = (state_q == StGrant);
  assign y         = y_q;
  assign s         = s_q;
  assign gnt       = out_valid ? (4'b0001 << s_q) : 4'b0000;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: one instance with MAX_HOLD=4 and one with
// MAX_HOLD=1, sharing stimulus; expected values are hand-computed per scenario.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] d0, d1, d2, d3;
  logic       out_ready;

  logic       v4, v1;
  logic [3:0] y4, y1;
  logic [1:0] s4, s1;
  logic [3:0] g4, g1;

  int checks = 0;
  int errors = 0;

  // Observed bundles: {out_valid, gnt, s, y}
  logic [10:0] obs4, obs1, exp4, exp1;
  assign obs4 = {v4, g4, s4, y4};
  assign obs1 = {v1, g1, s1, y1};

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.WIDTH(4), .MAX_HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .out_ready(out_ready), .out_valid(v4), .y(y4), .s(s4), .gnt(g4)
  );

  mux4_rr_arbiter #(.WIDTH(4), .MAX_HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .out_ready(out_ready), .out_valid(v1), .y(y1), .s(s1), .gnt(g1)
  );

  task automatic do_reset();
    rst_n = 1'b0; req = 4'b0000; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; out_ready = 1'b1;
    d0 = 4'h1; d1 = 4'h2; d2 = 4'h5; d3 = 4'he;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      exp4 = 11'b0;
      checks++;
      if (obs4 !== exp4) begin
        errors++; $display("FAIL reset_h4 cycle %0d got %b want %b", i, obs4, exp4);
      end
      checks++;
      if (obs1 !== exp4) begin
        errors++; $display("FAIL reset_h1 cycle %0d got %b want %b", i, obs1, exp4);
      end
    end
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [3:0] dv;
    do_reset();
    req = 4'b0010; d1 = 4'b0010; out_ready = 1'b1;
    dv = 4'b0010;
    // Nine consecutive valid beats on requester 1, spanning re-grants with no bubble.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      exp4 = {1'b1, 4'b0010, 2'd1, dv};
      checks++;
      if (obs4 !== exp4) begin
        errors++; $display("FAIL single_beat %0d got %b want %b", i, obs4, exp4);
      end
      dv = 4'(i * 3 + 7);
      d1 = dv;
    end
    req = 4'b0000;
  endtask

  task automatic test_round_robin();
    logic [1:0] es [5];
    logic [3:0] ey [5];
    es = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    ey = '{4'b0001, 4'b0010, 4'b0101, 4'b1110, 4'b0001};
    do_reset();
    d0 = 4'b0001; d1 = 4'b0010; d2 = 4'b0101; d3 = 4'b1110;
    req = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp1 = {1'b1, 4'b0001 << es[i], es[i], ey[i]};
      checks++;
      if (obs1 !== exp1) begin
        errors++; $display("FAIL rr_step %0d got %b want %b", i, obs1, exp1);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 4'b0100; d2 = 4'b0101; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp4 = {1'b1, 4'b0100, 2'd2, 4'b0101};
      checks++;
      if (obs4 !== exp4) begin
        errors++; $display("FAIL stall_hold %0d got %b want %b", i, obs4, exp4);
      end
      if (i == 0) begin
        d2 = 4'b1111; req = 4'b0110;
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    exp4 = {1'b1, 4'b0100, 2'd2, 4'b1111};
    checks++;
    if (obs4 !== exp4) begin
      errors++; $display("FAIL stall_release got %b want %b", obs4, exp4);
    end
    req = 4'b0000;
  endtask

  task automatic test_hold_limit();
    logic [1:0] es [9];
    es = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    do_reset();
    d0 = 4'h3; d1 = 4'hc;
    req = 4'b0011; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      exp4 = {1'b1, 4'b0001 << es[i], es[i], (es[i] == 2'd0) ? 4'h3 : 4'hc};
      checks++;
      if (obs4 !== exp4) begin
        errors++; $display("FAIL hold_beat %0d got %b want %b", i, obs4, exp4);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_drop_idle();
    do_reset();
    req = 4'b1000; d3 = 4'b1010; out_ready = 1'b0;
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    exp4 = {1'b1, 4'b1000, 2'd3, 4'b1010};
    checks++;
    if (obs4 !== exp4) begin
      errors++; $display("FAIL drop_stalled got %b want %b", obs4, exp4);
    end
    out_ready = 1'b1;
    @(negedge clk);
    exp4 = {1'b0, 4'b0000, 2'd3, 4'b1010};
    checks++;
    if (obs4 !== exp4) begin
      errors++; $display("FAIL drop_idle got %b want %b", obs4, exp4);
    end
    // Reset in the middle of a burst.
    req = 4'b1111; d0 = 4'h9;
    @(negedge clk);
    exp4 = {1'b1, 4'b0001, 2'd0, 4'h9};
    checks++;
    if (obs4 !== exp4) begin
      errors++; $display("FAIL burst_start got %b want %b", obs4, exp4);
    end
    rst_n = 1'b0;
    @(negedge clk);
    exp4 = 11'b0;
    checks++;
    if (obs4 !== exp4) begin
      errors++; $display("FAIL midburst_reset got %b want %b", obs4, exp4);
    end
    rst_n = 1'b1; req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_hold_limit();
    test_drop_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
